// File: rtl/dnn_image_loader_if.sv
// dnn_image_loader_if: pixel stream and result handshake bundle.
// master = host/consumer side, slave = loader side.
interface dnn_image_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_digit;

  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_digit
  );

  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_digit
  );
endinterface

// File: rtl/dnn_image_loader.sv
// dnn_image_loader: assembles a byte-stream frame, sequences dnn_top.
// Optional RUN watchdog enabled by defining DNN_LOADER_TIMEOUT_EN.
module dnn_image_loader #(
  parameter int NUM_PIXELS     = 784,
  parameter int PIX_W          = 16,
  parameter int FRAC_SHIFT     = 7,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  dnn_image_loader_if.slave       bus,
  output logic signed [PIX_W-1:0] image_vector [NUM_PIXELS],
  output logic                    dnn_start,
  input  logic                    dnn_done,
  input  logic [3:0]              dnn_digit,
  output logic                    err_frame,
  output logic                    err_timeout,
  output logic                    busy
);
  localparam int CNT_W = $clog2(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    RUN,
    REPORT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       res_digit;
  logic [PIX_W-1:0] pix_ext;
  logic [PIX_W-1:0] pix_val;
  logic             s_ready;
  logic             beat;

  assign pix_ext = {{(PIX_W-8){1'b0}}, bus.s_data};
  assign pix_val = pix_ext << FRAC_SHIFT;

  // Handshake outputs come straight from the state register.
  assign s_ready       = (state == FILL) || (state == DRAIN);
  assign bus.s_ready   = s_ready;
  assign bus.res_valid = (state == REPORT);
  assign bus.res_digit = res_digit;
  assign dnn_start     = (state == RUN);
  assign busy          = (state != FILL);
  assign beat          = bus.s_valid && s_ready;

`ifdef DNN_LOADER_TIMEOUT_EN
  localparam logic [19:0] WD_LIMIT =
    20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wd;
`else
  assign err_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      res_digit <= '0;
      err_frame <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++)
        image_vector[i] <= '0;
`ifdef DNN_LOADER_TIMEOUT_EN
      wd          <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      err_frame <= 1'b0;
`ifdef DNN_LOADER_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      unique case (state)
        FILL: begin
          if (beat) begin
            image_vector[cnt] <= $signed(pix_val);
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (bus.s_last) begin
                state <= RUN;
`ifdef DNN_LOADER_TIMEOUT_EN
                wd <= '0;
`endif
              end else begin
                err_frame <= 1'b1;
                state     <= DRAIN;
              end
            end else if (bus.s_last) begin
              // short frame: restart at index 0
              err_frame <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beat && bus.s_last) begin
            cnt   <= '0;
            state <= FILL;
          end
        end
        RUN: begin
          if (dnn_done) begin
            res_digit <= dnn_digit;
            state     <= REPORT;
          end
`ifdef DNN_LOADER_TIMEOUT_EN
          else if (wd == WD_LIMIT) begin
            err_timeout <= 1'b1;
            state       <= FILL;
          end else begin
            wd <= wd + 20'd1;
          end
`endif
        end
        REPORT: begin
          if (bus.res_ready)
            state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_dnn_image_loader.sv
// tb_dnn_image_loader: scenario tasks with queue-based scoreboard.
// Watchdog scenario depends on DNN_LOADER_TIMEOUT_EN.
module tb_dnn_image_loader;
  localparam int NP = 784;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [15:0] iv [NP];
  logic              dnn_start;
  logic              dnn_done;
  logic [3:0]        dnn_digit;
  logic              err_frame;
  logic              err_timeout;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          idx;
    logic [15:0] val;
  } pix_exp_t;

  pix_exp_t   pix_q[$];
  logic [3:0] dig_q[$];

  dnn_image_loader_if bus ();

  dnn_image_loader #(
    .NUM_PIXELS(NP),
    .PIX_W(16),
    .FRAC_SHIFT(7),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .image_vector(iv),
    .dnn_start(dnn_start),
    .dnn_done(dnn_done),
    .dnn_digit(dnn_digit),
    .err_frame(err_frame),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(int i, int m, int a);
    return 8'((i * m + a) % 256);
  endfunction

  function automatic logic [15:0] scaled(logic [7:0] d);
    logic [15:0] w;
    w = {8'd0, d};
    return w << 7;
  endfunction

  task automatic push_pix(int idx, int m, int a);
    pix_exp_t e;
    e.idx = idx;
    e.val = scaled(pix(idx, m, a));
    pix_q.push_back(e);
  endtask

  task automatic send_beat(logic [7:0] d, logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic stream(int n, int last_at, int m, int a);
    for (int i = 0; i < n; i++)
      send_beat(pix(i, m, a), i == last_at);
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;
    dnn_done      = 1'b0;
    dnn_digit     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_s_ready got %b want 1", bus.s_ready);
    end
    n_cmp++;
    if (dnn_start !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_start_busy got %b%b want 00",
               dnn_start, busy);
    end
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.res_digit !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_result got %b/%0d want 0/0",
               bus.res_valid, bus.res_digit);
    end
    n_cmp++;
    if (err_frame !== 1'b0 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_err got %b%b want 00",
               err_frame, err_timeout);
    end
    n_cmp++;
    if (iv[0] !== 16'sd0 || iv[NP-1] !== 16'sd0) begin
      n_bad++;
      $display("FAIL rst_vector got %0d,%0d want 0,0",
               iv[0], iv[NP-1]);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame;
    pix_exp_t e;
    int       bad_cyc;
    logic [3:0] d;
    push_pix(0, 1, 0);
    push_pix(5, 1, 0);
    push_pix(255, 1, 0);
    push_pix(256, 1, 0);
    push_pix(783, 1, 0);
    stream(NP, NP - 1, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (dnn_start !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_start got start=%b rdy=%b want 1/0",
               dnn_start, bus.s_ready);
    end
    while (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      n_cmp++;
      if (iv[e.idx] !== e.val) begin
        n_bad++;
        $display("FAIL frame_pix[%0d] got %0d want %0d",
                 e.idx, iv[e.idx], e.val);
      end
    end
    bad_cyc = 0;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      if (dnn_start !== 1'b1) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++;
      $display("FAIL run_hold got %0d drop cycles want 0", bad_cyc);
    end
    dnn_done  = 1'b1;
    dnn_digit = 4'd7;
    dig_q.push_back(4'd7);
    @(posedge clk);
    #1;
    dnn_done  = 1'b0;
    dnn_digit = 4'd0;
    @(negedge clk);
    n_cmp++;
    if (dnn_start !== 1'b0 || bus.res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL report_entry got start=%b vld=%b want 0/1",
               dnn_start, bus.res_valid);
    end
    bad_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_digit !== 4'd7 ||
          bus.s_ready !== 1'b0)
        bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++;
      $display("FAIL report_hold got %0d bad cycles want 0",
               bad_cyc);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    d = dig_q.pop_front();
    n_cmp++;
    if (bus.res_digit !== d) begin
      n_bad++;
      $display("FAIL report_digit got %0d want %0d",
               bus.res_digit, d);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL after_hs got vld=%b rdy=%b want 0/1",
               bus.res_valid, bus.s_ready);
    end
  endtask

  task automatic test_short_frame;
    pix_exp_t e;
    logic [3:0] d;
    stream(100, 99, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (err_frame !== 1'b1 || busy !== 1'b0 ||
        bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL short_err got err=%b busy=%b rdy=%b want 1/0/1",
               err_frame, busy, bus.s_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (err_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL short_pulse got %b want 0", err_frame);
    end
    push_pix(0, 1, 3);
    push_pix(99, 1, 3);
    push_pix(100, 1, 3);
    push_pix(783, 1, 3);
    stream(NP, NP - 1, 1, 3);
    @(negedge clk);
    n_cmp++;
    if (dnn_start !== 1'b1 || err_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL short_next got start=%b err=%b want 1/0",
               dnn_start, err_frame);
    end
    while (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      n_cmp++;
      if (iv[e.idx] !== e.val) begin
        n_bad++;
        $display("FAIL short_pix[%0d] got %0d want %0d",
                 e.idx, iv[e.idx], e.val);
      end
    end
    dnn_done  = 1'b1;
    dnn_digit = 4'd4;
    dig_q.push_back(4'd4);
    @(posedge clk);
    #1;
    dnn_done      = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    d = dig_q.pop_front();
    n_cmp++;
    if (bus.res_valid !== 1'b1 || bus.res_digit !== d) begin
      n_bad++;
      $display("FAIL short_res got %b/%0d want 1/%0d",
               bus.res_valid, bus.res_digit, d);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_long_frame;
    pix_exp_t e;
    int err_cnt;
    int start_seen;
    logic err_at_783;
    err_cnt    = 0;
    start_seen = 0;
    err_at_783 = 1'b0;
    push_pix(0, 7, 1);
    push_pix(15, 7, 1);
    push_pix(783, 7, 1);
    for (int i = 0; i < 800; i++) begin
      send_beat(pix(i, 7, 1), i == 799);
      @(negedge clk);
      if (err_frame === 1'b1) err_cnt++;
      if (dnn_start !== 1'b0) start_seen++;
      if (i == 783) err_at_783 = err_frame;
    end
    n_cmp++;
    if (err_cnt != 1 || err_at_783 !== 1'b1) begin
      n_bad++;
      $display("FAIL long_err got %0d pulses at783=%b want 1/1",
               err_cnt, err_at_783);
    end
    n_cmp++;
    if (start_seen != 0) begin
      n_bad++;
      $display("FAIL long_start got %0d cycles want 0", start_seen);
    end
    n_cmp++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL long_idle got busy=%b rdy=%b want 0/1",
               busy, bus.s_ready);
    end
    while (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      n_cmp++;
      if (iv[e.idx] !== e.val) begin
        n_bad++;
        $display("FAIL long_pix[%0d] got %0d want %0d",
                 e.idx, iv[e.idx], e.val);
      end
    end
  endtask

  task automatic test_reset_in_run;
    stream(NP, NP - 1, 3, 5);
    @(negedge clk);
    n_cmp++;
    if (dnn_start !== 1'b1) begin
      n_bad++;
      $display("FAIL rrun_start got %b want 1", dnn_start);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dnn_start !== 1'b0 || busy !== 1'b0 ||
        bus.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rrun_async got start=%b busy=%b vld=%b want 000",
               dnn_start, busy, bus.res_valid);
    end
    n_cmp++;
    if (iv[5] !== 16'sd0 || iv[783] !== 16'sd0) begin
      n_bad++;
      $display("FAIL rrun_vector got %0d,%0d want 0,0",
               iv[5], iv[783]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.s_ready !== 1'b1 || dnn_start !== 1'b0) begin
      n_bad++;
      $display("FAIL rrun_release got rdy=%b start=%b want 1/0",
               bus.s_ready, dnn_start);
    end
  endtask

  task automatic test_back_to_back;
    pix_exp_t e;
    logic [3:0] d;
    dnn_done      = 1'b1;
    bus.res_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      dnn_digit = (f == 0) ? 4'd12 : 4'd9;
      dig_q.push_back(dnn_digit);
      push_pix(1, 5, 2 + f * 198);
      push_pix(400, 5, 2 + f * 198);
      stream(NP, NP - 1, 5, 2 + f * 198);
      @(negedge clk);
      n_cmp++;
      if (dnn_start !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_start[%0d] got %b want 1", f, dnn_start);
      end
      @(negedge clk);
      d = dig_q.pop_front();
      n_cmp++;
      if (dnn_start !== 1'b0 || bus.res_valid !== 1'b1 ||
          bus.res_digit !== d) begin
        n_bad++;
        $display("FAIL b2b_res[%0d] got %b/%b/%0d want 0/1/%0d",
                 f, dnn_start, bus.res_valid, bus.res_digit, d);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.s_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_turn[%0d] got rdy=%b vld=%b want 1/0",
                 f, bus.s_ready, bus.res_valid);
      end
      while (pix_q.size() > 0) begin
        e = pix_q.pop_front();
        n_cmp++;
        if (iv[e.idx] !== e.val) begin
          n_bad++;
          $display("FAIL b2b_pix[%0d] got %0d want %0d",
                   e.idx, iv[e.idx], e.val);
        end
      end
    end
    dnn_done      = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_watchdog;
    int first;
    int vld_seen;
    first    = -1;
    vld_seen = 0;
    dnn_done = 1'b0;
    stream(NP, NP - 1, 1, 0);
    @(negedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (err_timeout === 1'b1 && first < 0) first = k;
      if (bus.res_valid !== 1'b0) vld_seen++;
    end
`ifdef DNN_LOADER_TIMEOUT_EN
    n_cmp++;
    if (first != 100) begin
      n_bad++;
      $display("FAIL wd_pulse got cycle %0d want 100", first);
    end
    n_cmp++;
    if (dnn_start !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_exit got start=%b rdy=%b want 0/1",
               dnn_start, bus.s_ready);
    end
`else
    n_cmp++;
    if (first != -1) begin
      n_bad++;
      $display("FAIL wd_absent got pulse at %0d want none", first);
    end
    n_cmp++;
    if (dnn_start !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_wait got start=%b want 1", dnn_start);
    end
    dnn_done = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    dnn_done = 1'b0;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
`endif
    n_cmp++;
    if (vld_seen != 0) begin
      n_bad++;
      $display("FAIL wd_no_result got %0d cycles want 0", vld_seen);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_short_frame();
    test_long_frame();
    test_reset_in_run();
    test_back_to_back();
    test_watchdog();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
